// File: rtl/dmem_lsu_if.sv
// Pipeline-side request/response channel of the dmem load/store unit.
// The pipeline drives the master side and the LSU sits on the slave side.
// Data is 128 bits wide. Byte lane k of a word is bits [8k+7:8k].
// The LSU's store byte-enable for lane k is req_mask[k].
// As a result, the mask MSB selects the most significant data byte.
interface dmem_lsu_if #(
  parameter int AW = 8,
  parameter int DW = 128,
  parameter int NB = DW / 8
);
  logic          req_valid;
  logic          req_ready;
  logic          req_wr;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [NB-1:0] req_mask;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, req_mask, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, req_mask, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/dmem_lsu.sv
// Load/store unit for the Troy Wide Word Processor data memory.
// The unit handles one request at a time.
// dmem has no byte enables, so a partial store is done as read-modify-write.
// Load data returns on a registered response channel that honours backpressure.
// Every output is a register, so no combinational path runs from the inputs to an output.
// Optional feature: define DMEM_LSU_PERF_EN to add three counters.
//   - perf_loads, perf_stores and perf_stalls, each 32 bits.
//   - The counters saturate instead of wrapping.
module dmem_lsu #(
  parameter int AW = 8,
  parameter int DW = 128,
  parameter int NB = DW / 8
) (
  input  logic          clk,
  input  logic          reset,
  dmem_lsu_if.slave     bus,
  output logic [AW-1:0] memAddr,
  output logic [DW-1:0] dataIn,
  output logic          wrEn,
  output logic          memEn,
  input  logic [DW-1:0] dataOut
`ifdef DMEM_LSU_PERF_EN
  ,
  output logic [31:0]   perf_loads,
  output logic [31:0]   perf_stores,
  output logic [31:0]   perf_stalls
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    RET,
    WB,
    RSP
  } state_t;

  localparam logic [NB-1:0] FULL_MASK = '1;

  state_t        state;
  logic          reqWr;
  logic [NB-1:0] reqMask;
  logic [DW-1:0] reqWdata;
  logic [DW-1:0] mergedWord;
  logic          accept;

  assign accept = bus.req_valid & bus.req_ready;

  // Merge the store bytes into the word read back from dmem, using the latched byte mask.
  always_comb begin
    mergedWord = dataOut;
    for (int k = 0; k < NB; k++) begin
      if (reqMask[k]) begin
        mergedWord[8*k +: 8] = reqWdata[8*k +: 8];
      end
    end
  end

  // Request FSM. The memory strobes and the handshake outputs are all registered here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      memEn         <= 1'b0;
      wrEn          <= 1'b0;
      memAddr       <= '0;
      dataIn        <= '0;
      reqWr         <= 1'b0;
      reqMask       <= '0;
      reqWdata      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            reqWr    <= bus.req_wr;
            reqMask  <= bus.req_mask;
            reqWdata <= bus.req_wdata;
            if (!(bus.req_wr && bus.req_mask == '0)) begin
              state         <= ISSUE;
              bus.req_ready <= 1'b0;
              memEn         <= 1'b1;
              memAddr       <= bus.req_addr;
              wrEn          <= bus.req_wr && (bus.req_mask == FULL_MASK);
              if (bus.req_wr && (bus.req_mask == FULL_MASK)) begin
                dataIn <= bus.req_wdata;
              end
            end
          end
        end
        ISSUE: begin
          memEn <= 1'b0;
          wrEn  <= 1'b0;
          if (reqWr && (reqMask == FULL_MASK)) begin
            state         <= IDLE;
            bus.req_ready <= 1'b1;
          end else begin
            state <= RET;
          end
        end
        RET: begin
          if (!reqWr) begin
            bus.rsp_data  <= dataOut;
            bus.rsp_valid <= 1'b1;
            state         <= RSP;
          end else begin
            reqWdata <= mergedWord;
            dataIn   <= mergedWord;
            memEn    <= 1'b1;
            wrEn     <= 1'b1;
            state    <= WB;
          end
        end
        WB: begin
          memEn         <= 1'b0;
          wrEn          <= 1'b0;
          state         <= IDLE;
          bus.req_ready <= 1'b1;
        end
        RSP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.req_ready <= 1'b1;
            state         <= IDLE;
          end
        end
        default: begin
          state         <= IDLE;
          bus.req_ready <= 1'b1;
          bus.rsp_valid <= 1'b0;
          memEn         <= 1'b0;
          wrEn          <= 1'b0;
        end
      endcase
    end
  end

`ifdef DMEM_LSU_PERF_EN
  // Saturating activity counters.
  // A load or store counts when it is accepted.
  // A stall counts on each cycle where a request waits with req_ready low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_loads  <= '0;
      perf_stores <= '0;
      perf_stalls <= '0;
    end else begin
      if (accept && !bus.req_wr && perf_loads != '1) begin
        perf_loads <= perf_loads + 32'd1;
      end
      if (accept && bus.req_wr && perf_stores != '1) begin
        perf_stores <= perf_stores + 32'd1;
      end
      if (bus.req_valid && !bus.req_ready && perf_stalls != '1) begin
        perf_stalls <= perf_stalls + 32'd1;
      end
    end
  end
`endif

endmodule
